// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports (instruction fetch, load/store) and the
//   shared memory port of mem_arbiter. Clock and reset are not part of the
//   bundle and stay plain ports on the arbiter.
//
//   Signals:
//     ifu_req / ifu_addr             fetch read request and address
//     ifu_rdata / ifu_valid          fetch read data and completion pulse
//     lsu_req / lsu_we / lsu_addr    load/store request, direction, address
//     lsu_wdata / lsu_wmask          store data and byte mask
//     lsu_rdata / lsu_valid          load data and completion pulse
//     m_req / m_we / m_addr          memory request, write enable, address
//     m_wdata / m_wmask              memory write data and byte mask
//     m_ready / m_rdata              memory completion and read data
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (requesters and memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic [63:0] ifu_rdata;
  logic        ifu_valid;

  logic        lsu_req;
  logic        lsu_we;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic [63:0] lsu_rdata;
  logic        lsu_valid;

  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  logic        m_ready;
  logic [63:0] m_rdata;

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_rdata, ifu_valid,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_rdata, lsu_valid,
    output m_req, m_we, m_addr, m_wdata, m_wmask,
    input  m_ready, m_rdata
  );

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_rdata, ifu_valid,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_rdata, lsu_valid,
    input  m_req, m_we, m_addr, m_wdata, m_wmask,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an instruction-fetch unit (read only) and a
//   load/store unit. One transaction is in flight at a time:
//     IDLE -> BUSY_IFU/BUSY_LSU (wait for m_ready) -> RESP (valid pulse) -> IDLE
//   The granted request is captured into registers at the grant edge and the
//   memory port is driven from those registers until m_ready.
//
//   Ports:
//     ACLK     clock
//     ARESETn  synchronous active-low reset
//     bus      mem_arbiter_if.slave (requester ports + memory port)
//
//   Configuration:
//     MEM_ARB_RR_EN  defined   -> simultaneous requests alternate (round-robin)
//                    undefined -> simultaneous requests go to the LSU
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic         ACLK,
  input  logic         ARESETn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IFU = 2'd1,
    BUSY_LSU = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        grant;       // a requester is accepted this cycle
  logic        grant_lsu;   // 1 = that requester is the LSU
  logic        busy;
  logic        last_grant;  // 0 = IFU, 1 = LSU; also names the port in flight

  logic        m_req_q;
  logic        m_we_q;
  logic [63:0] m_addr_q;
  logic [63:0] m_wdata_q;
  logic [7:0]  m_wmask_q;
  logic [63:0] ifu_rdata_q;
  logic [63:0] lsu_rdata_q;
  logic        ifu_valid_q;
  logic        lsu_valid_q;

  assign busy = (state == BUSY_IFU) || (state == BUSY_LSU);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_lsu  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ifu_req || bus.lsu_req) begin
          grant = 1'b1;
`ifdef MEM_ARB_RR_EN
          // On a tie, serve whoever did not win last time.
          if (bus.ifu_req && bus.lsu_req) begin
            grant_lsu = ~last_grant;
          end else begin
            grant_lsu = bus.lsu_req;
          end
`else
          grant_lsu = bus.lsu_req;
`endif
          next_state = grant_lsu ? BUSY_LSU : BUSY_IFU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        if (bus.m_ready) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture, memory port drive, response capture.
  // Requests seen outside IDLE never produce a grant, and m_ready is only
  // acted on while busy, so stray handshakes are ignored.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wmask_q   <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      // Valids are single-cycle pulses covering the RESP state.
      ifu_valid_q <= 1'b0;
      lsu_valid_q <= 1'b0;

      if (grant) begin
        last_grant <= grant_lsu;
        m_req_q    <= 1'b1;
        if (grant_lsu) begin
          m_addr_q  <= bus.lsu_addr;
          m_we_q    <= bus.lsu_we;
          m_wdata_q <= bus.lsu_wdata;
          m_wmask_q <= bus.lsu_wmask;
        end else begin
          // Fetches are always reads with no write payload.
          m_addr_q  <= bus.ifu_addr;
          m_we_q    <= 1'b0;
          m_wdata_q <= '0;
          m_wmask_q <= '0;
        end
      end else if (busy && bus.m_ready) begin
        m_req_q <= 1'b0;
        if (last_grant) begin
          lsu_valid_q <= 1'b1;
          if (!m_we_q) begin
            lsu_rdata_q <= bus.m_rdata;
          end
        end else begin
          ifu_valid_q <= 1'b1;
          ifu_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wmask   = m_wmask_q;
  assign bus.ifu_rdata = ifu_rdata_q;
  assign bus.lsu_rdata = lsu_rdata_q;
  assign bus.ifu_valid = ifu_valid_q;
  assign bus.lsu_valid = lsu_valid_q;

endmodule
